// File: rtl/mux_sel_pkg.sv
// Shared types and helpers for the mux select scheduler.
package mux_sel_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t CH_A = 2'd0;
  localparam ch_idx_t CH_B = 2'd1;
  localparam ch_idx_t CH_C = 2'd2;
  localparam ch_idx_t CH_D = 2'd3;

  function automatic logic [3:0] ch_to_onehot(input ch_idx_t ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner search over four requests, starting after ptr and wrapping.
// MUX_SEL_FIXED_PRIO_EN selects fixed priority a > b > c > d instead.
module rr_pick
  import mux_sel_pkg::*;
(
  input  logic [3:0] req,
  input  ch_idx_t    ptr,
  output ch_idx_t    win,
  output logic       any
);

  ch_idx_t    base;
  logic [7:0] req_dbl;
  logic [3:0] rot;
  ch_idx_t    off;

`ifdef MUX_SEL_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign base       = CH_A;
`else
  assign base = ptr + 2'd1;
`endif

  // Rotate so the search origin sits at bit 0, then take the lowest set bit.
  assign req_dbl = {req, req};
  assign rot     = 4'(req_dbl >> base);

  always_comb begin
    off = CH_A;
    if (rot[0])      off = CH_A;
    else if (rot[1]) off = CH_B;
    else if (rot[2]) off = CH_C;
    else if (rot[3]) off = CH_D;
  end

  assign win = base + off;
  assign any = |req;

endmodule

// File: rtl/mux_sel_sched.sv
// Select scheduler driving s1/s2 of the downstream 4:1 mux with dwell-limited grants.
// MUX_SEL_FIXED_PRIO_EN switches the winner search to fixed priority.
module mux_sel_sched
  import mux_sel_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [3:0]         req,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               ack,
  output logic               s1,
  output logic               s2,
  output logic [3:0]         gnt,
  output logic               gnt_valid,
  output logic               expire
);

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] len_q, len_d;
  logic [DWELL_W-1:0] dwell_len;
  ch_idx_t            ptr_q, ptr_d;
  ch_idx_t            ch_q, ch_d;
  ch_idx_t            pick_win;
  logic               pick_any;
  logic               start_ok;
  logic               end_cnt;
  logic               grant_end;
  logic               load;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [3:0]         gnt_q, gnt_d;

  rr_pick u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .win (pick_win),
    .any (pick_any)
  );

  assign dwell_len = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign start_ok  = en && pick_any;
  assign end_cnt   = (cnt_q == len_q - DWELL_W'(1));
  assign grant_end = (state_q == ST_GRANT) && (end_cnt || ack || !req[ch_q]);
  assign load      = start_ok && ((state_q == ST_IDLE) || grant_end);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_GRANT;
      ST_GRANT: if (grant_end) state_d = start_ok ? ST_GRANT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Grant bookkeeping, next output values, and the end-of-grant pulse.
  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    ptr_d = ptr_q;
    ch_d  = ch_q;
    if (load) begin
      cnt_d = '0;
      len_d = dwell_len;
      ptr_d = pick_win;
      ch_d  = pick_win;
    end else if (grant_end) begin
      cnt_d = '0;
    end else if (state_q == ST_GRANT) begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
    gnt_valid_d = (state_d == ST_GRANT);
    s1_d        = gnt_valid_d & ch_d[1];
    s2_d        = gnt_valid_d & ch_d[0];
    gnt_d       = gnt_valid_d ? ch_to_onehot(ch_d) : 4'b0000;
    expire      = rst_n && grant_end;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      len_q       <= DWELL_W'(1);
      ptr_q       <= CH_D;
      ch_q        <= CH_A;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      gnt_q       <= 4'b0000;
      gnt_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign s1        = s1_q;
  assign s2        = s2_q;
  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;

endmodule
